match_referee: RTL and testbench

Downstream match controller for the two-player fighting core. It consumes both players' registered health and location once per game turn, detects knock-outs and turn-limit timeouts, and keeps round scores for a best-of-N match. It drives the player blocks' reset between rounds and reports the round and match result to the display logic.

---
 rtl/fight_pkg.sv | 59 +++++
 rtl/turn_timer.sv | 26 ++
 rtl/match_referee.sv | 179 +++++++++++++++++
 tb/tb_match_referee.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fight_pkg.sv
// Shared types for the fighting core: move encodings, referee states, winner codes
// and the small decision helpers the match referee uses. SUDDEN_DEATH_EN adds ST_SUDDEN.
package fight_pkg;

  localparam logic [3:0] MOVE_IDLE   = 4'b0001;
  localparam logic [3:0] MOVE_LEFT   = 4'b0010;
  localparam logic [3:0] MOVE_RIGHT  = 4'b0100;
  localparam logic [3:0] MOVE_ATTACK = 4'b1000;

  typedef enum logic [1:0] {
    WIN_NONE  = 2'b00,
    WIN_LEFT  = 2'b01,
    WIN_RIGHT = 2'b10,
    WIN_DRAW  = 2'b11
  } winner_t;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ARM        = 3'd1,
    ST_FIGHT      = 3'd2,
    ST_ROUND_END  = 3'd3,
    ST_MATCH_OVER = 3'd4
`ifdef SUDDEN_DEATH_EN
    , ST_SUDDEN   = 3'd5
`endif
  } ref_state_t;

  function automatic logic [1:0] sat_inc(input logic [1:0] v);
    return (v == 2'd3) ? v : v + 2'd1;
  endfunction

  function automatic winner_t ko_decision(input logic [1:0] lh, input logic [1:0] rh);
    if (lh == 2'd0 && rh == 2'd0) return WIN_DRAW;
    if (lh == 2'd0)               return WIN_RIGHT;
    if (rh == 2'd0)               return WIN_LEFT;
    return WIN_NONE;
  endfunction

  function automatic winner_t health_decision(input logic [1:0] lh, input logic [1:0] rh);
    if (lh > rh) return WIN_LEFT;
    if (lh < rh) return WIN_RIGHT;
    return WIN_NONE;
  endfunction

  // Positions share one axis: the larger left location / smaller right location wins,
  // so equal positions always draw.
  function automatic winner_t location_decision(input logic [1:0] ll, input logic [1:0] rl);
    if (ll > rl) return WIN_LEFT;
    if (ll < rl) return WIN_RIGHT;
    return WIN_DRAW;
  endfunction

  function automatic winner_t score_compare(input logic [1:0] lr, input logic [1:0] rr);
    if (lr > rr) return WIN_LEFT;
    if (lr < rr) return WIN_RIGHT;
    return WIN_DRAW;
  endfunction

endpackage

// File: rtl/turn_timer.sv
// Loadable down-counter for the per-round turn budget; stops at zero.
module turn_timer #(
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && !zero) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/match_referee.sv
// Best-of-N match controller: KO / timeout detection, round scoring, player reset sequencing.
// Optional macro SUDDEN_DEATH_EN replaces the location tie-break with a sudden-death state.
module match_referee
  import fight_pkg::*;
#(
  parameter int unsigned TURNS_PER_ROUND     = 30,
  parameter int unsigned ROUNDS_TO_WIN       = 2,
  parameter int unsigned MAX_ROUNDS          = 5,
  parameter int unsigned INTERMISSION_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       turn_valid,
  input  logic [1:0] left_health,
  input  logic [1:0] right_health,
  input  logic [1:0] left_location,
  input  logic [1:0] right_location,
  output logic       player_rst_n,
  output logic       round_active,
  output logic [2:0] round_num,
  output logic [1:0] left_rounds,
  output logic [1:0] right_rounds,
  output logic [1:0] round_winner,
  output logic       match_done,
  output logic [1:0] match_winner,
  output logic [7:0] turns_left
);

  localparam int unsigned   TW         = $clog2(TURNS_PER_ROUND + 1);
  localparam int unsigned   IW         = (INTERMISSION_CYCLES > 1) ? $clog2(INTERMISSION_CYCLES) : 1;
  localparam logic [TW-1:0] TURNS_INIT = TW'(TURNS_PER_ROUND);
  localparam logic [IW-1:0] INTER_LAST = IW'(INTERMISSION_CYCLES - 1);
  localparam logic [2:0]    MAX_R      = 3'(MAX_ROUNDS);
  localparam logic [1:0]    WIN_R      = 2'(ROUNDS_TO_WIN);

  ref_state_t    state, state_next;
  winner_t       decision;
  logic          timer_load, timer_dec, turns_zero;
  logic [TW-1:0] turns_cnt;
  logic [IW-1:0] inter_cnt, inter_d;

  logic       player_rst_d, active_d, done_d;
  logic [2:0] round_num_d;
  logic [1:0] left_rounds_d, right_rounds_d, round_winner_d, match_winner_d;

  turn_timer #(.WIDTH(TW)) u_turn_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (timer_load),
    .load_value (TURNS_INIT),
    .dec        (timer_dec),
    .count      (turns_cnt),
    .zero       (turns_zero)
  );

  assign turns_left = 8'(turns_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // KO is checked before the turn budget, so a KO on the last turn is never a timeout.
  always_comb begin
    state_next = state;
    decision   = WIN_NONE;
    timer_load = 1'b0;
    timer_dec  = 1'b0;
    case (state)
      ST_IDLE: if (start) state_next = ST_ARM;
      ST_ARM: begin
        timer_load = 1'b1;
        state_next = ST_FIGHT;
      end
      ST_FIGHT: begin
        if (turn_valid) begin
          decision = ko_decision(left_health, right_health);
          if (decision == WIN_NONE) begin
            timer_dec = !turns_zero;
            if (turns_cnt == TW'(1)) begin
              decision = health_decision(left_health, right_health);
              if (decision == WIN_NONE) begin
`ifdef SUDDEN_DEATH_EN
                state_next = ST_SUDDEN;
`else
                decision = location_decision(left_location, right_location);
`endif
              end
            end
          end
          if (decision != WIN_NONE) state_next = ST_ROUND_END;
        end
      end
`ifdef SUDDEN_DEATH_EN
      ST_SUDDEN: begin
        if (turn_valid) begin
          decision = ko_decision(left_health, right_health);
          if (decision == WIN_NONE) decision = health_decision(left_health, right_health);
          if (decision != WIN_NONE) state_next = ST_ROUND_END;
        end
      end
`endif
      ST_ROUND_END: begin
        if (inter_cnt == INTER_LAST) begin
          if (left_rounds == WIN_R || right_rounds == WIN_R || round_num == MAX_R)
            state_next = ST_MATCH_OVER;
          else
            state_next = ST_ARM;
        end
      end
      ST_MATCH_OVER: if (start) state_next = ST_ARM;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    player_rst_d   = (state_next != ST_ARM);
    done_d         = (state_next == ST_MATCH_OVER);
`ifdef SUDDEN_DEATH_EN
    active_d       = (state_next == ST_FIGHT) || (state_next == ST_SUDDEN);
`else
    active_d       = (state_next == ST_FIGHT);
`endif
    round_num_d    = round_num;
    left_rounds_d  = left_rounds;
    right_rounds_d = right_rounds;
    round_winner_d = round_winner;
    match_winner_d = match_winner;
    inter_d        = (state == ST_ROUND_END) ? inter_cnt + 1'b1 : '0;

    if (state_next == ST_ARM) begin
      if (state == ST_IDLE || state == ST_MATCH_OVER) begin
        round_num_d    = 3'd1;
        left_rounds_d  = '0;
        right_rounds_d = '0;
        match_winner_d = WIN_NONE;
      end else begin
        round_num_d = round_num + 3'd1;
      end
    end

    if (state == ST_ARM) round_winner_d = WIN_NONE;

    if (decision != WIN_NONE) begin
      round_winner_d = decision;
      if (decision == WIN_LEFT)  left_rounds_d  = sat_inc(left_rounds);
      if (decision == WIN_RIGHT) right_rounds_d = sat_inc(right_rounds);
    end

    if (state_next == ST_MATCH_OVER && state != ST_MATCH_OVER)
      match_winner_d = score_compare(left_rounds_d, right_rounds_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      player_rst_n <= 1'b0;
      round_active <= 1'b0;
      match_done   <= 1'b0;
      round_num    <= '0;
      left_rounds  <= '0;
      right_rounds <= '0;
      round_winner <= WIN_NONE;
      match_winner <= WIN_NONE;
      inter_cnt    <= '0;
    end else begin
      player_rst_n <= player_rst_d;
      round_active <= active_d;
      match_done   <= done_d;
      round_num    <= round_num_d;
      left_rounds  <= left_rounds_d;
      right_rounds <= right_rounds_d;
      round_winner <= round_winner_d;
      match_winner <= match_winner_d;
      inter_cnt    <= inter_d;
    end
  end

endmodule

// File: tb/tb_match_referee.sv
// Scoreboard bench for match_referee: a turn-level model queues expected round/match results.
module tb_match_referee;

  localparam int T_TURNS = 3;
  localparam int T_WIN   = 2;
  localparam int T_MAXR  = 5;
  localparam int T_INTER = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       turn_valid = 1'b0;
  logic [1:0] left_health = 2'd3, right_health = 2'd3;
  logic [1:0] left_location = 2'd0, right_location = 2'd0;
  logic       player_rst_n, round_active, match_done;
  logic [2:0] round_num;
  logic [1:0] left_rounds, right_rounds, round_winner, match_winner;
  logic [7:0] turns_left;

  match_referee #(
    .TURNS_PER_ROUND     (T_TURNS),
    .ROUNDS_TO_WIN       (T_WIN),
    .MAX_ROUNDS          (T_MAXR),
    .INTERMISSION_CYCLES (T_INTER)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .turn_valid     (turn_valid),
    .left_health    (left_health),
    .right_health   (right_health),
    .left_location  (left_location),
    .right_location (right_location),
    .player_rst_n   (player_rst_n),
    .round_active   (round_active),
    .round_num      (round_num),
    .left_rounds    (left_rounds),
    .right_rounds   (right_rounds),
    .round_winner   (round_winner),
    .match_done     (match_done),
    .match_winner   (match_winner),
    .turns_left     (turns_left)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [1:0] w; logic [1:0] lr; logic [1:0] rr; } round_exp_t;
  typedef struct packed { logic [1:0] w; logic [2:0] rn; logic [1:0] lr; logic [1:0] rr; } match_exp_t;

  round_exp_t round_q[$];
  match_exp_t match_q[$];
  logic [7:0] turn_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int exp_turns, exp_lr, exp_rr, exp_round;
  bit in_sudden, match_over;

  task automatic check_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic logic [7:0] turn(input int lh, input int rh, input int ll, input int rl);
    return {2'(lh), 2'(rh), 2'(ll), 2'(rl)};
  endfunction

  task automatic add(input int n, input logic [7:0] t);
    for (int i = 0; i < n; i++) turn_q.push_back(t);
  endtask

  // Reference behaviour of one accepted turn.
  task automatic model_turn(input logic [7:0] t, output logic [1:0] dec);
    logic [1:0] lh, rh, ll, rl;
    round_exp_t r;
    {lh, rh, ll, rl} = t;
    dec = 2'b00;
    if (lh == 0 && rh == 0)      dec = 2'b11;
    else if (lh == 0)            dec = 2'b10;
    else if (rh == 0)            dec = 2'b01;
    else if (in_sudden) begin
      if (lh > rh)      dec = 2'b01;
      else if (lh < rh) dec = 2'b10;
    end else begin
      exp_turns--;
      if (exp_turns == 0) begin
        if (lh > rh)      dec = 2'b01;
        else if (lh < rh) dec = 2'b10;
        else begin
`ifdef SUDDEN_DEATH_EN
          in_sudden = 1'b1;
`else
          if (ll > rl)      dec = 2'b01;
          else if (ll < rl) dec = 2'b10;
          else              dec = 2'b11;
`endif
        end
      end
    end
    if (dec != 2'b00) begin
      if (dec == 2'b01 && exp_lr < 3) exp_lr++;
      if (dec == 2'b10 && exp_rr < 3) exp_rr++;
      in_sudden = 1'b0;
      r.w = dec; r.lr = 2'(exp_lr); r.rr = 2'(exp_rr);
      round_q.push_back(r);
    end
  endtask

  logic [1:0] prev_rw = 2'b00;
  logic       prev_done = 1'b0;
  round_exp_t mon_r;
  match_exp_t mon_m;

  always @(negedge clk) begin
    if (rst_n) begin
      if (round_winner != 2'b00 && prev_rw == 2'b00) begin
        if (round_q.size() == 0) check_eq("sb_round_extra", round_winner, 0);
        else begin
          mon_r = round_q.pop_front();
          check_eq("round_winner", round_winner, mon_r.w);
          check_eq("left_rounds", left_rounds, mon_r.lr);
          check_eq("right_rounds", right_rounds, mon_r.rr);
        end
      end
      if (match_done && !prev_done) begin
        if (match_q.size() == 0) check_eq("sb_match_extra", match_done, 0);
        else begin
          mon_m = match_q.pop_front();
          check_eq("match_winner", match_winner, mon_m.w);
          check_eq("match_round_num", round_num, mon_m.rn);
          check_eq("match_left_rounds", left_rounds, mon_m.lr);
          check_eq("match_right_rounds", right_rounds, mon_m.rr);
        end
      end
    end
    prev_rw   <= round_winner;
    prev_done <= match_done;
  end

  task automatic check_reset();
    check_eq("rst_player_rst_n", player_rst_n, 0);
    check_eq("rst_round_active", round_active, 0);
    check_eq("rst_round_num", round_num, 0);
    check_eq("rst_left_rounds", left_rounds, 0);
    check_eq("rst_right_rounds", right_rounds, 0);
    check_eq("rst_round_winner", round_winner, 0);
    check_eq("rst_match_winner", match_winner, 0);
    check_eq("rst_match_done", match_done, 0);
    check_eq("rst_turns_left", turns_left, 0);
  endtask

  task automatic start_match();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("arm_player_rst_n", player_rst_n, 0);
    check_eq("arm_round_active", round_active, 0);
    check_eq("arm_round_num", round_num, 1);
    check_eq("arm_scores", {left_rounds, right_rounds}, 0);
    check_eq("arm_match_done", match_done, 0);
    @(negedge clk);
    check_eq("fight_active", round_active, 1);
    check_eq("fight_player_rst_n", player_rst_n, 1);
    check_eq("fight_turns_left", turns_left, T_TURNS);
    // start during FIGHT must be ignored
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("start_ignored_round", round_num, 1);
    check_eq("start_ignored_rst", player_rst_n, 1);
    exp_round = 1; exp_lr = 0; exp_rr = 0; exp_turns = T_TURNS; in_sudden = 1'b0;
  endtask

  task automatic drive_turn(input logic [7:0] t, output logic [1:0] dec);
    {left_health, right_health, left_location, right_location} = t;
    turn_valid = 1'b1;
    model_turn(t, dec);
    @(negedge clk);
    turn_valid = 1'b0;
    if (dec == 2'b00) begin
      check_eq("turns_left", turns_left, exp_turns);
      check_eq("round_active", round_active, 1);
    end
  endtask

  // Runs at the first ROUND_END negedge; stray turn_valid/start pulses must be ignored.
  task automatic after_round();
    int n;
    match_exp_t m;
    n = 0;
    if (exp_lr == T_WIN || exp_rr == T_WIN || exp_round == T_MAXR) begin
      m.w  = (exp_lr > exp_rr) ? 2'b01 : (exp_lr < exp_rr) ? 2'b10 : 2'b11;
      m.rn = 3'(exp_round); m.lr = 2'(exp_lr); m.rr = 2'(exp_rr);
      match_q.push_back(m);
      while (!match_done && n < 20) begin
        n++;
        turn_valid = (n == 2); start = (n == 3);
        if (n == 2) begin left_health = 2'd0; right_health = 2'd0; end
        @(negedge clk);
      end
      turn_valid = 1'b0; start = 1'b0;
      check_eq("intermission_to_match_over", n, T_INTER);
      check_eq("match_done", match_done, 1);
      check_eq("match_over_inactive", round_active, 0);
      match_over = 1'b1;
    end else begin
      while (player_rst_n && !round_active && n < 20) begin
        n++;
        turn_valid = (n == 2); start = (n == 3);
        if (n == 2) begin left_health = 2'd0; right_health = 2'd0; end
        @(negedge clk);
      end
      turn_valid = 1'b0; start = 1'b0;
      check_eq("intermission_cycles", n, T_INTER);
      check_eq("arm_pulse", player_rst_n, 0);
      check_eq("arm_keeps_scores", {left_rounds, right_rounds}, {2'(exp_lr), 2'(exp_rr)});
      exp_round++;
      exp_turns = T_TURNS;
      @(negedge clk);
      check_eq("next_round_active", round_active, 1);
      check_eq("next_round_num", round_num, exp_round);
      check_eq("next_round_winner_clear", round_winner, 0);
      check_eq("next_round_turns", turns_left, T_TURNS);
    end
  endtask

  task automatic mid_reset();
    check_eq("pre_reset_active", round_active, 1);
    #2 rst_n = 1'b0;
    #1 check_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("release_player_rst_n", player_rst_n, 1);
    check_eq("release_round_num", round_num, 0);
  endtask

  task automatic play_match();
    logic [1:0] dec;
    logic [7:0] t;
    start_match();
    match_over = 1'b0;
    while (!match_over && turn_q.size() > 0) begin
      dec = 2'b00;
      while (dec == 2'b00 && turn_q.size() > 0) begin
        t = turn_q.pop_front();
        drive_turn(t, dec);
      end
      if (dec != 2'b00) after_round();
    end
    turn_q.delete();
    if (!match_over) mid_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    check_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_reset_player_rst_n", player_rst_n, 1);
    check_eq("idle_round_active", round_active, 0);

    // Match 1: KO on the last budgeted turn, then a first-turn KO ends the match.
    add(1, turn(3, 3, 0, 0)); add(1, turn(3, 2, 0, 0)); add(1, turn(3, 0, 0, 0));
    add(1, turn(3, 0, 0, 0));
    play_match();

    // Match 2: timeouts by health, location draw, right timeout, double KO, location win.
    add(3, turn(3, 2, 0, 0)); add(3, turn(2, 2, 1, 1)); add(3, turn(1, 3, 0, 0));
    add(1, turn(0, 0, 0, 0)); add(3, turn(2, 2, 2, 1));
    play_match();

    // Match 3: five double-KO draws reach the round cap.
    add(5, turn(0, 0, 0, 0));
    play_match();

    // Match 4: equal timeout then a health split, a right win, then reset mid-fight.
    add(4, turn(3, 3, 1, 1)); add(1, turn(3, 2, 1, 1)); add(1, turn(0, 3, 0, 0));
    play_match();

    check_eq("sb_round_pending", round_q.size(), 0);
    check_eq("sb_match_pending", match_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
